// File: rtl/pool_window_sequencer_if.sv
// Sequencer-side bus of the max-pool read path.
// Grouped signals:
//   start, rows_avail, dout_rdy          : frame control, write-side progress, downstream ready
//   rm_rd_addr                           : ring RAM read address
//   op_din_en, op_din_eop, dout_en       : operator strobes aligned to RAM/operator latency
//   rows_consumed, busy, done            : progress and status back to the frame controller
// master : frame controller / write side (drives start, rows_avail, dout_rdy)
// slave  : the window sequencer
interface pool_window_sequencer_if #(
  parameter int RD_ADDR_WIDTH = 7,
  parameter int ROW_CNT_WIDTH = 4
);
  logic                     start;
  logic [ROW_CNT_WIDTH-1:0] rows_avail;
  logic                     dout_rdy;
  logic [RD_ADDR_WIDTH-1:0] rm_rd_addr;
  logic                     op_din_en;
  logic                     op_din_eop;
  logic                     dout_en;
  logic [ROW_CNT_WIDTH-1:0] rows_consumed;
  logic                     busy;
  logic                     done;

  modport master (
    output start, rows_avail, dout_rdy,
    input  rm_rd_addr, op_din_en, op_din_eop, dout_en, rows_consumed, busy, done
  );

  modport slave (
    input  start, rows_avail, dout_rdy,
    output rm_rd_addr, op_din_en, op_din_eop, dout_en, rows_consumed, busy, done
  );
endinterface

// File: rtl/pool_window_sequencer.sv
// Read-side scheduler for a max-pool layer. Walks output pixels (oy, ox),
// channel groups and window elements (ky, kx), issuing one ring-RAM read per
// element that lies inside the input image. Window issue waits for enough
// input rows and for downstream ready; operator strobes are delayed to match
// RAM read latency and the operator result latency.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : pool_window_sequencer_if.slave (start, rows_avail, dout_rdy in;
//          rm_rd_addr, op_din_en, op_din_eop, dout_en, rows_consumed, busy, done out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start
// S_WAIT  | next window pending on input rows and downstream ready
// S_ISSUE | one read address per cycle for the current window
// S_DRAIN | last window issued, letting the delay pipelines empty
// S_DONE  | one-cycle completion pulse
module pool_window_sequencer #(
  parameter int DB_W_IN           = 8,
  parameter int DB_H_IN           = 8,
  parameter int DB_W_OUT          = 4,
  parameter int DB_H_OUT          = 4,
  parameter int CH_GROUPS         = 2,
  parameter int WB_W              = 3,
  parameter int WB_H              = 3,
  parameter int STRIDE_W          = 2,
  parameter int STRIDE_H          = 2,
  parameter int RING_LENGTH       = 5,
  parameter int RD_ADDR_WIDTH     = 7,
  parameter int ROW_CNT_WIDTH     = 4,
  parameter int DATA_ACCESS_DELAY = 5,
  parameter int OP_DELAY          = 1
) (
  input logic clk,
  input logic rst,
  pool_window_sequencer_if.slave bus
);

  localparam int OY_W      = (DB_H_OUT    > 1) ? $clog2(DB_H_OUT)    : 1;
  localparam int OX_W      = (DB_W_OUT    > 1) ? $clog2(DB_W_OUT)    : 1;
  localparam int GRP_W     = (CH_GROUPS   > 1) ? $clog2(CH_GROUPS)   : 1;
  localparam int KY_W      = (WB_H        > 1) ? $clog2(WB_H)        : 1;
  localparam int KX_W      = (WB_W        > 1) ? $clog2(WB_W)        : 1;
  localparam int SLOT_W    = (RING_LENGTH > 1) ? $clog2(RING_LENGTH) : 1;
  localparam int DRAIN_CYC = DATA_ACCESS_DELAY + OP_DELAY;
  localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t state, state_n;

  logic [OY_W-1:0]          oy;
  logic [OX_W-1:0]          ox;
  logic [GRP_W-1:0]         grp;
  logic [KY_W-1:0]          ky;
  logic [KX_W-1:0]          kx;
  logic [SLOT_W-1:0]        base_slot;   // ring slot of row oy*STRIDE_H
  logic [SLOT_W-1:0]        elem_slot;   // ring slot of row oy*STRIDE_H+ky
  logic [SLOT_W-1:0]        next_base;
  logic [DRN_W-1:0]         drain_cnt;
  logic [RD_ADDR_WIDTH-1:0] addr_q;
  logic [ROW_CNT_WIDTH-1:0] consumed_q;
  logic                     busy_q;
  logic                     done_q;

  // index 0 is aligned with rm_rd_addr; the top index is aligned with RAM data
  logic [DATA_ACCESS_DELAY:0] en_pipe;
  logic [DATA_ACCESS_DELAY:0] eop_pipe;
  logic [OP_DELAY-1:0]        res_pipe;

  int   row_base, col_base, need_row, ky_last, kx_last, addr_int, nb;
  logic rows_ok, elem_last, grp_last, ox_last, oy_last, frame_last, issue;

  // Window geometry: edge windows are clipped by shortening the kx/ky range,
  // so ISSUE never spends a cycle on an element outside the image.
  always_comb begin
    row_base = int'(oy) * STRIDE_H;
    col_base = int'(ox) * STRIDE_W;
    need_row = row_base + WB_H - 1;
    if (need_row > DB_H_IN - 1) need_row = DB_H_IN - 1;
    ky_last  = (DB_H_IN - row_base >= WB_H) ? WB_H - 1 : DB_H_IN - row_base - 1;
    kx_last  = (DB_W_IN - col_base >= WB_W) ? WB_W - 1 : DB_W_IN - col_base - 1;
    addr_int = (int'(elem_slot) * DB_W_IN + col_base + int'(kx)) * CH_GROUPS + int'(grp);
    rows_ok  = int'(bus.rows_avail) > need_row;
    elem_last  = (int'(kx) == kx_last) && (int'(ky) == ky_last);
    grp_last   = int'(grp) == CH_GROUPS - 1;
    ox_last    = int'(ox)  == DB_W_OUT - 1;
    oy_last    = int'(oy)  == DB_H_OUT - 1;
    frame_last = elem_last && grp_last && ox_last && oy_last;
    nb = int'(base_slot) + (STRIDE_H % RING_LENGTH);
    if (nb >= RING_LENGTH) nb = nb - RING_LENGTH;
    next_base = SLOT_W'(nb);
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_n = S_WAIT;
      S_WAIT:  if (rows_ok && bus.dout_rdy) state_n = S_ISSUE;
      S_ISSUE: begin
        issue = 1'b1;
        if (elem_last) state_n = frame_last ? S_DRAIN : S_WAIT;
      end
      S_DRAIN: if (drain_cnt == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (int'(s) == RING_LENGTH - 1) ? '0 : s + SLOT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      oy         <= '0;
      ox         <= '0;
      grp        <= '0;
      ky         <= '0;
      kx         <= '0;
      base_slot  <= '0;
      elem_slot  <= '0;
      drain_cnt  <= '0;
      addr_q     <= '0;
      consumed_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_pipe    <= '0;
      eop_pipe   <= '0;
      res_pipe   <= '0;
    end else begin
      busy_q      <= (state_n != S_IDLE);
      done_q      <= (state_n == S_DONE);
      en_pipe[0]  <= issue;
      eop_pipe[0] <= issue && elem_last;
      for (int i = 1; i <= DATA_ACCESS_DELAY; i++) begin
        en_pipe[i]  <= en_pipe[i-1];
        eop_pipe[i] <= eop_pipe[i-1];
      end
      res_pipe[0] <= eop_pipe[DATA_ACCESS_DELAY];
      for (int i = 1; i < OP_DELAY; i++) res_pipe[i] <= res_pipe[i-1];

      drain_cnt <= (state == S_DRAIN) ? drain_cnt - DRN_W'(1) : DRN_W'(DRAIN_CYC);

      if (state == S_IDLE && bus.start) begin
        oy         <= '0;
        ox         <= '0;
        grp        <= '0;
        ky         <= '0;
        kx         <= '0;
        base_slot  <= '0;
        elem_slot  <= '0;
        consumed_q <= '0;
      end

      if (issue) begin
        addr_q <= RD_ADDR_WIDTH'(addr_int);
        if (!elem_last) begin
          if (int'(kx) == kx_last) begin
            kx        <= '0;
            ky        <= ky + KY_W'(1);
            elem_slot <= slot_inc(elem_slot);
          end else begin
            kx <= kx + KX_W'(1);
          end
        end else begin
          kx <= '0;
          ky <= '0;
          if (!grp_last) begin
            grp       <= grp + GRP_W'(1);
            elem_slot <= base_slot;
          end else begin
            grp <= '0;
            if (!ox_last) begin
              ox        <= ox + OX_W'(1);
              elem_slot <= base_slot;
            end else begin
              ox <= '0;
              if (!oy_last) begin
                oy         <= oy + OY_W'(1);
                consumed_q <= consumed_q + ROW_CNT_WIDTH'(STRIDE_H);
                base_slot  <= next_base;
                elem_slot  <= next_base;
              end else begin
                // rows past the last window are never read either
                oy         <= '0;
                consumed_q <= ROW_CNT_WIDTH'(DB_H_IN);
                base_slot  <= '0;
                elem_slot  <= '0;
              end
            end
          end
        end
      end
    end
  end

  assign bus.rm_rd_addr    = addr_q;
  assign bus.op_din_en     = en_pipe[DATA_ACCESS_DELAY];
  assign bus.op_din_eop    = eop_pipe[DATA_ACCESS_DELAY];
  assign bus.dout_en       = res_pipe[OP_DELAY-1];
  assign bus.rows_consumed = consumed_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
module tb_pool_window_sequencer;
  localparam int W_IN = 8, H_IN = 8, W_OUT = 4, H_OUT = 4, GRPS = 2;
  localparam int WB_W = 3, WB_H = 3, SW = 2, SH = 2, RING = 5;
  localparam int D = 5, OPD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pool_window_sequencer_if #(.RD_ADDR_WIDTH(7), .ROW_CNT_WIDTH(4)) bus ();

  pool_window_sequencer #(
    .DB_W_IN(W_IN), .DB_H_IN(H_IN), .DB_W_OUT(W_OUT), .DB_H_OUT(H_OUT),
    .CH_GROUPS(GRPS), .WB_W(WB_W), .WB_H(WB_H), .STRIDE_W(SW), .STRIDE_H(SH),
    .RING_LENGTH(RING), .RD_ADDR_WIDTH(7), .ROW_CNT_WIDTH(4),
    .DATA_ACCESS_DELAY(D), .OP_DELAY(OPD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit eop; int ra; } obs_t;
  typedef struct { int addr; bit eop; int oy; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   n_windows;
  int   total = 0;
  int   bad = 0;

  int   hist_addr [0:7];
  int   hist_ra   [0:7];
  int   n_dout, n_done, n_eop, misalign, bad_eop;
  bit   prev_eop = 1'b0;

  // Observed element stream: the address on the bus D cycles before each op_din_en.
  always @(negedge clk) begin
    obs_t o;
    for (int i = 7; i > 0; i--) begin
      hist_addr[i] = hist_addr[i-1];
      hist_ra[i]   = hist_ra[i-1];
    end
    hist_addr[0] = int'(bus.rm_rd_addr);
    hist_ra[0]   = int'(bus.rows_avail);
    if (bus.op_din_en) begin
      o.addr = hist_addr[D];
      o.eop  = bus.op_din_eop;
      o.ra   = hist_ra[D];
      obs_q.push_back(o);
    end
    if (bus.op_din_eop) n_eop++;
    if (bus.op_din_eop && !bus.op_din_en) bad_eop++;
    if (bus.dout_en) n_dout++;
    if (bus.dout_en !== prev_eop) misalign++;
    prev_eop = bus.op_din_eop;
    if (bus.done) n_done++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    n_dout = 0; n_done = 0; n_eop = 0; misalign = 0; bad_eop = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  // Reference: plain nested loops over the frame with clipping and modulo ring rows.
  task automatic build_model();
    exp_t win_q[$];
    exp_t e;
    exp_q.delete();
    n_windows = 0;
    for (int oy = 0; oy < H_OUT; oy++)
      for (int ox = 0; ox < W_OUT; ox++)
        for (int g = 0; g < GRPS; g++) begin
          win_q.delete();
          for (int ky = 0; ky < WB_H; ky++)
            for (int kx = 0; kx < WB_W; kx++) begin
              int r, c;
              r = oy * SH + ky;
              c = ox * SW + kx;
              if (r < H_IN && c < W_IN) begin
                e.addr = ((r % RING) * W_IN + c) * GRPS + g;
                e.eop  = 1'b0;
                e.oy   = oy;
                win_q.push_back(e);
              end
            end
          for (int i = 0; i < win_q.size(); i++) begin
            e = win_q[i];
            e.eop = (i == win_q.size() - 1);
            exp_q.push_back(e);
          end
          if (win_q.size() > 0) n_windows++;
        end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.rows_avail = '0; bus.dout_rdy = 1'b0;
    tick(3);
    total++; if (bus.rm_rd_addr !== 7'd0)    begin bad++; $display("FAIL reset rm_rd_addr: got %0d, required 0", bus.rm_rd_addr); end
    total++; if (bus.op_din_en !== 1'b0)     begin bad++; $display("FAIL reset op_din_en: got %b, required 0", bus.op_din_en); end
    total++; if (bus.op_din_eop !== 1'b0)    begin bad++; $display("FAIL reset op_din_eop: got %b, required 0", bus.op_din_eop); end
    total++; if (bus.dout_en !== 1'b0)       begin bad++; $display("FAIL reset dout_en: got %b, required 0", bus.dout_en); end
    total++; if (bus.rows_consumed !== 4'd0) begin bad++; $display("FAIL reset rows_consumed: got %0d, required 0", bus.rows_consumed); end
    total++; if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset busy: got %b, required 0", bus.busy); end
    total++; if (bus.done !== 1'b0)          begin bad++; $display("FAIL reset done: got %b, required 0", bus.done); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_full_frame(input string name);
    int k, first_bad;
    clear_obs();
    bus.rows_avail = 4'd8;
    bus.dout_rdy   = 1'b1;
    pulse_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy after start: got %b, required 1", name, bus.busy); end
    k = 0;
    while (n_done == 0 && k < 2000) begin tick(1); k++; end
    total++; if (n_done == 0) begin bad++; $display("FAIL %s timeout: done not seen in %0d cycles, required a done pulse", name, k); end
    tick(5);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL %s read count: got %0d, required %0d", name, obs_q.size(), exp_q.size()); end
    total++; if (n_dout != n_windows) begin bad++; $display("FAIL %s dout_en count: got %0d, required %0d", name, n_dout, n_windows); end
    first_bad = -1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].eop != exp_q[i].eop) begin first_bad = i; break; end
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s stream element %0d: got addr=%0d eop=%0d, required addr=%0d eop=%0d",
               name, first_bad, obs_q[first_bad].addr, obs_q[first_bad].eop, exp_q[first_bad].addr, exp_q[first_bad].eop);
    end
    total++; if (bus.rows_consumed !== 4'(H_IN)) begin bad++; $display("FAIL %s rows_consumed: got %0d, required %0d", name, bus.rows_consumed, H_IN); end
    total++; if (n_done != 1) begin bad++; $display("FAIL %s done pulses: got %0d, required 1", name, n_done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s busy after done: got %b, required 0", name, bus.busy); end
    total++; if (misalign != 0) begin bad++; $display("FAIL %s dout_en vs op_din_eop delay: got %0d misaligned cycles, required 0", name, misalign); end
    total++; if (bad_eop != 0) begin bad++; $display("FAIL %s op_din_eop without op_din_en: got %0d, required 0", name, bad_eop); end
  endtask

  task automatic test_first_window();
    int ea [9] = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
    total++;
    if (obs_q.size() < 9) begin
      bad++; $display("FAIL first_window size: got %0d elements, required at least 9", obs_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (i > 0) total++;
        if (obs_q[i].addr != ea[i] || obs_q[i].eop != (i == 8)) begin
          bad++;
          $display("FAIL first_window element %0d: got addr=%0d eop=%0d, required addr=%0d eop=%0d",
                   i, obs_q[i].addr, obs_q[i].eop, ea[i], (i == 8));
        end
      end
    end
  endtask

  task automatic test_edge_window();
    int ea [4] = '{29, 31, 45, 47};
    int n;
    n = obs_q.size();
    total++;
    if (n < 5) begin
      bad++; $display("FAIL edge_window size: got %0d elements, required at least 5", n);
    end else begin
      if (obs_q[n-5].eop != 1'b1) begin
        bad++; $display("FAIL edge_window preceding eop: got %0d, required 1", obs_q[n-5].eop);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_q[n-4+i].addr != ea[i] || obs_q[n-4+i].eop != (i == 3)) begin
          bad++;
          $display("FAIL edge_window element %0d: got addr=%0d eop=%0d, required addr=%0d eop=%0d",
                   i, obs_q[n-4+i].addr, obs_q[n-4+i].eop, ea[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_row_gating();
    int oy0_cnt, k, first_bad;
    oy0_cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].oy == 0) oy0_cnt++;
    clear_obs();
    bus.rows_avail = 4'd2;
    bus.dout_rdy   = 1'b1;
    pulse_start();
    tick(25);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL row_gating rows2: got %0d reads, required 0", obs_q.size()); end
    bus.rows_avail = 4'd3;
    tick(150);
    total++; if (obs_q.size() != oy0_cnt) begin bad++; $display("FAIL row_gating rows3: got %0d reads, required %0d", obs_q.size(), oy0_cnt); end
    total++; if (bus.rows_consumed !== 4'(SH)) begin bad++; $display("FAIL row_gating rows_consumed: got %0d, required %0d", bus.rows_consumed, SH); end
    bus.rows_avail = 4'd4;
    tick(30);
    total++; if (obs_q.size() != oy0_cnt) begin bad++; $display("FAIL row_gating rows4: got %0d reads, required %0d", obs_q.size(), oy0_cnt); end
    bus.rows_avail = 4'd5;
    tick(30);
    total++; if (obs_q.size() <= oy0_cnt) begin bad++; $display("FAIL row_gating rows5: got %0d reads, required more than %0d", obs_q.size(), oy0_cnt); end
    bus.rows_avail = 4'd8;
    k = 0;
    while (n_done == 0 && k < 2000) begin tick(1); k++; end
    tick(5);
    total++; if (n_dout != n_windows) begin bad++; $display("FAIL row_gating dout_en count: got %0d, required %0d", n_dout, n_windows); end
    first_bad = (obs_q.size() == exp_q.size()) ? -1 : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].eop != exp_q[i].eop) begin first_bad = i; break; end
    total++; if (first_bad >= 0) begin bad++; $display("FAIL row_gating stream: first difference at element %0d, got %0d elements, required %0d", first_bad, obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int k, cnt, snap, first_bad;
    bit held;
    clear_obs();
    bus.rows_avail = 4'd8;
    bus.dout_rdy   = 1'b1;
    pulse_start();
    tick(40);
    bus.dout_rdy = 1'b0;
    tick(20);
    snap = int'(bus.rm_rd_addr);
    cnt  = obs_q.size();
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (int'(bus.rm_rd_addr) != snap) held = 1'b0;
    end
    total++; if (!held) begin bad++; $display("FAIL backpressure rm_rd_addr: got %0d, required stable at %0d", bus.rm_rd_addr, snap); end
    total++; if (obs_q.size() != cnt) begin bad++; $display("FAIL backpressure stall: got %0d reads, required %0d", obs_q.size(), cnt); end
    total++; if (cnt == 0 || !obs_q[(cnt > 0) ? cnt-1 : 0].eop) begin bad++; $display("FAIL backpressure boundary: got %0d reads without trailing eop, required a complete window", cnt); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL backpressure busy: got %b, required 1", bus.busy); end
    bus.dout_rdy = 1'b1;
    k = 0;
    while (n_done == 0 && k < 2000) begin tick(1); k++; end
    tick(5);
    total++; if (n_dout != n_windows) begin bad++; $display("FAIL backpressure dout_en count: got %0d, required %0d", n_dout, n_windows); end
    first_bad = (obs_q.size() == exp_q.size()) ? -1 : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i].addr != exp_q[i].addr || obs_q[i].eop != exp_q[i].eop) begin first_bad = i; break; end
    total++; if (first_bad >= 0) begin bad++; $display("FAIL backpressure stream: first difference at element %0d, got %0d elements, required %0d", first_bad, obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int k, first_bad, gate_bad, ra, need;
      clear_obs();
      ra = $urandom_range(0, 2);
      bus.rows_avail = 4'(ra);
      bus.dout_rdy   = ($urandom_range(0, 1) == 1);
      pulse_start();
      k = 0;
      while (n_done == 0 && k < 4000) begin
        bus.dout_rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0 && ra < H_IN) ra++;
        bus.rows_avail = 4'(ra);
        bus.start = (bus.busy && $urandom_range(0, 15) == 0);
        tick(1);
        k++;
      end
      bus.start = 1'b0;
      tick(10);
      total++; if (n_done != 1) begin bad++; $display("FAIL random%0d done pulses: got %0d, required 1", f, n_done); end
      total++; if (n_dout != n_windows) begin bad++; $display("FAIL random%0d dout_en count: got %0d, required %0d", f, n_dout, n_windows); end
      first_bad = (obs_q.size() == exp_q.size()) ? -1 : 0;
      gate_bad = -1;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        need = exp_q[i].oy * SH + WB_H - 1;
        if (need > H_IN - 1) need = H_IN - 1;
        if (gate_bad < 0 && obs_q[i].ra <= need) gate_bad = i;
        if (obs_q[i].addr != exp_q[i].addr || obs_q[i].eop != exp_q[i].eop) begin first_bad = i; break; end
      end
      total++; if (first_bad >= 0) begin bad++; $display("FAIL random%0d stream: first difference at element %0d, got %0d elements, required %0d", f, first_bad, obs_q.size(), exp_q.size()); end
      total++; if (gate_bad >= 0) begin bad++; $display("FAIL random%0d row gate: element %0d read with rows_avail=%0d, required more than %0d", f, gate_bad, obs_q[gate_bad].ra, exp_q[gate_bad].oy * SH + WB_H - 1); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL random%0d busy after done: got %b, required 0", f, bus.busy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    clear_obs();
    bus.rows_avail = 4'd8;
    bus.dout_rdy   = 1'b1;
    pulse_start();
    k = 0;
    while (n_eop < 9 && k < 500) begin tick(1); k++; end
    total++; if (n_eop < 9) begin bad++; $display("FAIL reset_mid timeout: got %0d windows, required 9", n_eop); end
    rst = 1'b1;
    tick(1);
    total++; if (bus.rm_rd_addr !== 7'd0)    begin bad++; $display("FAIL reset_mid rm_rd_addr: got %0d, required 0", bus.rm_rd_addr); end
    total++; if (bus.op_din_en !== 1'b0)     begin bad++; $display("FAIL reset_mid op_din_en: got %b, required 0", bus.op_din_en); end
    total++; if (bus.dout_en !== 1'b0)       begin bad++; $display("FAIL reset_mid dout_en: got %b, required 0", bus.dout_en); end
    total++; if (bus.rows_consumed !== 4'd0) begin bad++; $display("FAIL reset_mid rows_consumed: got %0d, required 0", bus.rows_consumed); end
    total++; if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset_mid busy: got %b, required 0", bus.busy); end
    rst = 1'b0;
    clear_obs();
    tick(20);
    total++; if (obs_q.size() != 0 || n_dout != 0) begin bad++; $display("FAIL reset_mid residue: got %0d reads and %0d dout_en, required 0 and 0", obs_q.size(), n_dout); end
    test_full_frame("after_reset");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rows_avail = '0;
    bus.dout_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin hist_addr[i] = 0; hist_ra[i] = 0; end
    build_model();
    test_reset();
    test_full_frame("full_frame");
    test_first_window();
    test_edge_window();
    test_row_gating();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
- Read-side scheduler for a max-pool layer built from a row ring-buffer RAM and an array of per-lane vector_max units.
- Walks every output pixel and channel group, issuing one RAM read address per window element, and generates op_din_en/op_din_eop aligned to RAM read latency.
- Gates window issue on input-row availability and downstream readiness.
- Publishes consumed-row progress so the write side can safely overwrite ring slots.

Parameters:
- DB_W_IN, 8, input width in pixels
- DB_H_IN, 8, input height in rows
- DB_W_OUT, 4, output width
- DB_H_OUT, 4, output height
- CH_GROUPS, 2, channel groups per pixel (input channels / lanes per RAM word)
- WB_W, 3, window width
- WB_H, 3, window height
- STRIDE_W, 2, horizontal stride
- STRIDE_H, 2, vertical stride
- RING_LENGTH, 5, input rows held in the ring RAM
- RD_ADDR_WIDTH, 7, RAM read address width
- ROW_CNT_WIDTH, 4, width of row counters (holds 0..DB_H_IN)
- DATA_ACCESS_DELAY, 5, cycles from rm_rd_addr to RAM data valid at the operators
- OP_DELAY, 1, cycles from op_din_eop to operator result valid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start pulse; ignored unless IDLE
- rows_avail  in  ROW_CNT_WIDTH  count of complete input rows written this frame (monotonic)
- dout_rdy  in  1  downstream can accept one result
- rm_rd_addr  out  RD_ADDR_WIDTH  ring RAM read address
- op_din_en  out  1  operator input valid
- op_din_eop  out  1  last element of current window
- dout_en  out  1  operator result valid this cycle
- rows_consumed  out  ROW_CNT_WIDTH  input rows no longer needed
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Every output registered.
- Reset values: rm_rd_addr=0, op_din_en=0, op_din_eop=0, dout_en=0, rows_consumed=0, busy=0, done=0, state=IDLE.
- Loop order, outermost first: oy, ox, grp, ky, kx.
- Element coordinates: row r=oy*STRIDE_H+ky; col c=ox*STRIDE_W+kx.
- Edge clipping (no padding): elements with r>=DB_H_IN or c>=DB_W_IN are skipped, not issued. Edge windows are shorter; op_din_eop marks the last issued element.
- Address: rm_rd_addr = ((r mod RING_LENGTH)*DB_W_IN + c)*CH_GROUPS + grp. Mod is computed by a wrapping ring-row counter, not a divider.
- IDLE: on start, zero counters, set busy, go to WAIT.
- WAIT: go to ISSUE only when both hold in the same cycle:
  - rows_avail > min(oy*STRIDE_H+WB_H-1, DB_H_IN-1)
  - dout_rdy=1
- ISSUE: one address per cycle, no stalls inside a window.
  - After the last element of a window, advance grp/ox/oy and return to WAIT.
  - After the last window of the frame, go to DRAIN.
- Output alignment:
  - op_din_en and op_din_eop are the issue strobe and last-element flag delayed DATA_ACCESS_DELAY cycles through a shift pipeline.
  - dout_en = op_din_eop delayed OP_DELAY cycles.
- rows_consumed = oy*STRIDE_H, updated when oy increments; equals DB_H_IN at frame end.
- DRAIN: wait DATA_ACCESS_DELAY+OP_DELAY cycles so the final dout_en has been emitted, then go to DONE.
- DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- Simultaneous events:
  - start during busy is ignored.
  - dout_rdy falling mid-window does not stall that window; it is sampled only in WAIT.
  - rows_avail decreasing is illegal and not checked.
- Reset mid-frame: state, counters and delay pipelines clear on the same edge. No op_din_en or dout_en is emitted after the reset edge.

Test Plan:
- Full frame, defaults, rows_avail=8, dout_rdy=1:
  - 242 reads total: 121 per group (11 rows x 11 cols summed over windows).
  - 32 dout_en pulses.
  - rows_consumed ends at 8; one done pulse; busy low afterwards.
- First window, group 0: addresses 0,2,4,16,18,20,32,34,36.
  - op_din_en first high exactly 5 cycles after address 0.
  - op_din_eop coincides with address 36's data.
  - dout_en follows 1 cycle later.
- Edge window oy=3, ox=3, grp=1:
  - 4 reads, rows 6,7 -> ring slots 1,2: addresses 29,31,45,47.
  - op_din_eop on 47's data.
- Row gating: rows_avail=2 -> no reads for 20 cycles. Set 3 -> first window issues. oy=1 stalls until rows_avail>=5.
- Backpressure: dout_rdy=0 at a window boundary holds WAIT with rm_rd_addr stable; raising it resumes with the next window. Total dout_en count is still 32.
- rst asserted during ISSUE of window 10: all outputs 0 next cycle. A fresh start then reproduces the full-frame results.
